// File: rtl/asu_ddr5_pkg.sv
// Shared DDR5 write-CRC definitions: burst geometry and controller states.
package asu_ddr5_pkg;

  // Data beats per BL16 burst on one x4 lane group (two nibbles per beat).
  localparam int CRC_BEATS = 8;
  // Width of a data beat and of the CRC code.
  localparam int CRC_W     = 8;

  // Sequencer states of the write-CRC controller.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FEED    = 2'd1,
    CAPTURE = 2'd2
  } crc_ctrl_state_e;

endpackage

// File: rtl/asu_ddr5_crc_ctrl.sv
// Write-CRC sequencer: forwards 8 data beats of a burst downstream, feeds them
// into the x4 CRC engine, then appends the CRC byte when write CRC is enabled
// and returns the engine's beat counter to 0 with one extra zero-data pulse.
module asu_ddr5_crc_ctrl
  import asu_ddr5_pkg::*;
#(
  parameter int DATA_W = CRC_W,
  parameter int BEATS  = CRC_BEATS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              crc_cfg_en_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_crc_o,
  input  logic              out_ready_i,
  output logic              crc_en_o,
  output logic [DATA_W-1:0] crc_data_o,
  input  logic [DATA_W-1:0] crc_code_i,
  output logic              busy_o
);

  localparam int              CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  crc_ctrl_state_e   state_reg;
  crc_ctrl_state_e   state_next;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic              cfg_q_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_crc_reg;

  logic out_free;
  logic accept;
  logic first_beat;
  logic cfg_eff;
  logic feed_beat;
  logic capture_fire;

  // The output register can take a new beat when empty or being drained now.
  assign out_free     = !out_valid_reg || out_ready_i;
  assign in_ready_o   = (state_reg != CAPTURE) && out_free;
  assign accept       = in_valid_i && in_ready_o;
  assign first_beat   = (beat_cnt_reg == '0);
  // The burst's CRC mode is fixed by the first beat; later toggles are ignored.
  assign cfg_eff      = first_beat ? crc_cfg_en_i : cfg_q_reg;
  assign feed_beat    = accept && cfg_eff;
  assign capture_fire = (state_reg == CAPTURE) && out_free;

  // The CAPTURE pulse carries zero data so the engine wraps its count to 0.
  assign crc_en_o   = feed_beat || capture_fire;
  assign crc_data_o = feed_beat ? in_data_i : '0;

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_crc_o   = out_crc_reg;
  assign busy_o      = (state_reg != IDLE);

  // Next-state selection: IDLE starts on a first beat, FEED ends on the last.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = FEED;
        end
      end
      FEED: begin
        if (accept && (beat_cnt_reg == LAST_BEAT)) begin
          state_next = cfg_q_reg ? CAPTURE : IDLE;
        end
      end
      CAPTURE: begin
        if (out_free) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, beat position within the burst and latched CRC mode.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      cfg_q_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + 1'b1;
        if (first_beat) begin
          cfg_q_reg <= crc_cfg_en_i;
        end
      end
    end
  end

  // Output register: data beat has priority, then the CRC byte, else drain.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_crc_reg   <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data_i;
      out_crc_reg   <= 1'b0;
    end else if (capture_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= crc_code_i;
      out_crc_reg   <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_asu_ddr5_crc_ctrl.sv
// Scoreboard bench for asu_ddr5_crc_ctrl with a behavioural CRC engine beside it.
module tb_asu_ddr5_crc_ctrl;

  logic       clk_i;
  logic       rst_i;
  logic       crc_cfg_en_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_crc_o;
  logic       out_ready_i;
  logic       crc_en_o;
  logic [7:0] crc_data_o;
  logic [7:0] crc_code_i;
  logic       busy_o;

  asu_ddr5_crc_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .crc_cfg_en_i (crc_cfg_en_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_crc_o    (out_crc_o),
    .out_ready_i  (out_ready_i),
    .crc_en_o     (crc_en_o),
    .crc_data_o   (crc_data_o),
    .crc_code_i   (crc_code_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // x^n mod (x^8 + x^2 + x + 1)
  function automatic logic [7:0] xpow(input int n);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < n; i++) begin
      v = v[7] ? ((v << 1) ^ 8'h07) : (v << 1);
    end
    return v;
  endfunction

  // CRC-8 of a 64-bit burst: remainder of M(x)*x^8, bit p = coefficient of x^p,
  // beat k occupying bits 8k..8k+7.
  function automatic logic [7:0] crc_ref(input logic [63:0] m);
    logic [7:0] r;
    r = 8'h00;
    for (int p = 0; p < 64; p++) begin
      if (m[p]) r = r ^ xpow(8 + p);
    end
    return r;
  endfunction

  // Behavioural engine: counts fed beats, shows the code only at count 8,
  // and the next pulse returns it to 0.
  int          eng_cnt;
  logic [63:0] eng_acc;
  int          pulse_cnt = 0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      eng_cnt <= 0;
      eng_acc <= '0;
    end else if (crc_en_o) begin
      pulse_cnt <= pulse_cnt + 1;
      if (eng_cnt == 8) begin
        eng_cnt <= 0;
        eng_acc <= '0;
      end else begin
        eng_acc[eng_cnt*8 +: 8] <= crc_data_o;
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  assign crc_code_i = (eng_cnt == 8) ? crc_ref(eng_acc) : 8'h00;

  // Scoreboard and bench state
  logic [8:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          hold_cnt = 0;
  logic        rand_ready = 1'b0;
  int          stall_cycles = 0;
  int          exp_pulses = 0;
  int          tb_beat = 0;
  logic        burst_cfg = 1'b0;
  logic [63:0] burst_msg = '0;
  logic [7:0]  bd [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every consumed output beat.
  task automatic monitor_loop();
    logic       stall_q;
    logic [7:0] d_q;
    logic       c_q;
    logic [8:0] e;
    stall_q = 1'b0;
    d_q = 8'h00;
    c_q = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        stall_q = 1'b0;
        continue;
      end
      if (stall_q) begin
        check("hold_valid", int'(out_valid_o), 1);
        check("hold_data", int'(out_data_o), int'(d_q));
        check("hold_crcflag", int'(out_crc_o), int'(c_q));
      end
      if (!busy_o) check("eng_idle_cnt", eng_cnt, 0);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", int'({out_crc_o, out_data_o}), 0);
        end else begin
          e = exp_q.pop_front();
          $display("beat data=0x%02h crc=%0d expected data=0x%02h crc=%0d",
                   out_data_o, out_crc_o, e[7:0], e[8]);
          check("out_data", int'(out_data_o), int'(e[7:0]));
          check("out_crc", int'(out_crc_o), int'(e[8]));
        end
      end
      stall_q = out_valid_o && !out_ready_i;
      d_q = out_data_o;
      c_q = out_crc_o;
    end
  endtask

  // Downstream ready: forced low while hold_cnt runs, else random or always high.
  task automatic ready_loop();
    forever begin
      @(posedge clk_i);
      #1;
      if (hold_cnt > 0) begin
        out_ready_i = 1'b0;
        hold_cnt--;
      end else begin
        out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  endtask

  // Present one beat from a negedge until accepted; record its expected output.
  task automatic send_beat(input logic [7:0] d, input logic set_hold);
    int w;
    w = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    while (!in_ready_o) begin
      @(negedge clk_i);
      w++;
      if (w > 200) begin
        check("accept_timeout", 0, 1);
        in_valid_i = 1'b0;
        return;
      end
    end
    stall_cycles += w;
    if (set_hold) hold_cnt = 5;
    if (tb_beat == 0) burst_cfg = crc_cfg_en_i;
    burst_msg[tb_beat*8 +: 8] = d;
    exp_q.push_back({1'b0, d});
    if (tb_beat == 7 && burst_cfg) begin
      exp_q.push_back({1'b1, crc_ref(burst_msg)});
      exp_pulses += 9;
    end
    tb_beat = (tb_beat + 1) % 8;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic send_burst(input logic cfg, input logic toggle4,
                            input logic hold_test, input logic gaps);
    int g;
    for (int i = 0; i < 8; i++) begin
      crc_cfg_en_i = (toggle4 && i >= 4) ? !cfg : cfg;
      send_beat(bd[i], hold_test && (i == 6 || i == 7));
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    if (hold_test) begin
      // Let CAPTURE complete, then hold the freshly loaded CRC byte.
      g = 0;
      while (hold_cnt != 0 && g < 50) begin
        @(negedge clk_i);
        g++;
      end
      @(negedge clk_i);
      hold_cnt = 5;
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy_o || out_valid_o) && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    check(name, int'(exp_q.size() == 0 && !busy_o && !out_valid_o), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, int'(in_ready_o), 1);
    check({name, "_out_valid"}, int'(out_valid_o), 0);
    check({name, "_out_data"}, int'(out_data_o), 0);
    check({name, "_out_crc"}, int'(out_crc_o), 0);
    check({name, "_crc_en"}, int'(crc_en_o), 0);
    check({name, "_crc_data"}, int'(crc_data_o), 0);
    check({name, "_busy"}, int'(busy_o), 0);
  endtask

  task automatic load_pattern(input logic [7:0] first);
    bd[0] = first;
    for (int i = 1; i < 8; i++) bd[i] = 8'h00;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) bd[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int pbase;
    int ebase;
    rst_i        = 1'b0;
    in_valid_i   = 1'b0;
    in_data_i    = 8'h00;
    crc_cfg_en_i = 1'b0;
    out_ready_i  = 1'b1;
    fork
      monitor_loop();
      ready_loop();
    join_none

    // Reset, then idle
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    rst_i = 1'b1;
    pbase = pulse_cnt;
    repeat (10) @(negedge clk_i);
    check_reset_outputs("idle");
    check("idle_pulses", pulse_cnt - pbase, 0);

    // CRC enabled 0x01,0x00x7 then zeros then 0x01 again
    pbase = pulse_cnt; ebase = exp_pulses;
    load_pattern(8'h01); send_burst(1'b1, 1'b0, 1'b0, 1'b0);
    drain("drain_en1");
    check("pulses_en1", pulse_cnt - pbase, exp_pulses - ebase);
    load_pattern(8'h00); send_burst(1'b1, 1'b0, 1'b0, 1'b0);
    load_pattern(8'h01); send_burst(1'b1, 1'b0, 1'b0, 1'b0);
    drain("drain_en2");
    check("pulses_en2", pulse_cnt - pbase, exp_pulses - ebase);

    // CRC disabled, enable toggled mid-burst
    pbase = pulse_cnt;
    load_random(); send_burst(1'b0, 1'b1, 1'b0, 1'b0);
    drain("drain_dis");
    check("pulses_dis", pulse_cnt - pbase, 0);

    // Throughput: disabled bursts back-to-back, no stall
    stall_cycles = 0;
    load_random(); send_burst(1'b0, 1'b0, 1'b0, 1'b0);
    load_random(); send_burst(1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_dis", stall_cycles, 0);
    drain("drain_tp_dis");
    // Throughput: enabled bursts back-to-back, one stall for the CRC beat
    stall_cycles = 0;
    load_random(); send_burst(1'b1, 1'b0, 1'b0, 1'b0);
    load_random(); send_burst(1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_en", stall_cycles, 1);
    drain("drain_tp_en");

    // Backpressure on beat 8 and during CAPTURE / CRC beat
    pbase = pulse_cnt; ebase = exp_pulses;
    load_pattern(8'h01); send_burst(1'b1, 1'b0, 1'b1, 1'b0);
    drain("drain_bp");
    check("pulses_bp", pulse_cnt - pbase, exp_pulses - ebase);

    // Randomized bursts with random backpressure and gaps
    rand_ready = 1'b1;
    pbase = pulse_cnt; ebase = exp_pulses;
    for (int b = 0; b < 12; b++) begin
      load_random();
      send_burst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    drain("drain_rand");
    check("pulses_rand", pulse_cnt - pbase, exp_pulses - ebase);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset after beat 3 of a CRC burst
    load_pattern(8'h01);
    crc_cfg_en_i = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(bd[i], 1'b0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    exp_q.delete();
    tb_beat = 0;
    @(negedge clk_i);
    check_reset_outputs("midrst");
    check("midrst_eng", eng_cnt, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    pbase = pulse_cnt; ebase = exp_pulses;
    load_pattern(8'h01); send_burst(1'b1, 1'b0, 1'b0, 1'b0);
    drain("drain_after_rst");
    check("pulses_after_rst", pulse_cnt - pbase, exp_pulses - ebase);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/asu_ddr5_crc_ctrl.md
# asu_ddr5_crc_ctrl

Write-CRC sequencer for one x4 DDR5 device lane group. Accepts a BL16 write burst as 8 byte-wide beats from the write-data path and streams them into the x4 CRC engine (`asu_ddr5_crc_x4`). It captures the 8-bit CRC code after the 8th beat and wraps the engine's internal beat counter back to 0. Downstream serializer logic receives the 8 data beats followed by one CRC beat when write CRC is enabled, or only the 8 data beats when it is not.

## Interface
- DATA_W, 8, data beat width; fixed to match the CRC engine.
- BEATS, 8, data beats per burst; fixed to match the CRC engine.

- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low; also drives the CRC engine reset.
- crc_cfg_en_i  in  1  write-CRC enable (mode-register image); sampled at the first beat of each burst.
- in_valid_i  in  1  write data beat valid.
- in_data_i  in  8  write data beat.
- in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o.
- out_valid_o  out  1  output beat valid (registered).
- out_data_o  out  8  output beat: data or CRC (registered).
- out_crc_o  out  1  high while the current output beat is the CRC byte.
- out_ready_i  in  1  downstream accepts the output beat.
- crc_en_o  out  1  to engine crc_en_i (combinational).
- crc_data_o  out  8  to engine crc_in_data_i (combinational).
- crc_code_i  in  8  from engine crc_code_o; nonzero only while the engine count is 8.
- busy_o  out  1  high when not in IDLE.

## Operation
- States: IDLE, FEED, CAPTURE.
- Output register free condition: free = !out_valid_o || out_ready_i.
- in_ready_o is high in IDLE or FEED when free; it is low in CAPTURE.
- Accepting a beat does the following:
  - loads out_data_o with in_data_i, sets out_valid_o = 1, sets out_crc_o = 0;
  - increments beat_cnt (3 bits, wraps 7 to 0).
- On a beat accepted with beat_cnt == 0:
  - latch cfg_q = crc_cfg_en_i;
  - IDLE moves to FEED.
- While cfg_q (or crc_cfg_en_i on the first beat) is high, each accepted beat drives crc_en_o = 1 and crc_data_o = in_data_i in the same cycle.
- crc_en_o = 0 otherwise, except in CAPTURE as described below.
- crc_data_o = 0 whenever the controller is not feeding a data beat.
- On acceptance of beat 8 (beat_cnt == 7):
  - if cfg_q = 1, go to CAPTURE;
  - otherwise go to IDLE.
- CAPTURE behaviour:
  - Hold until free.
  - Then load out_data_o = crc_code_i, out_crc_o = 1, out_valid_o = 1.
  - Pulse crc_en_o = 1 with crc_data_o = 0 for one cycle, which returns the engine count to 0.
  - Go to IDLE.
- out_valid_o clears when out_ready_i is high and no new beat or CRC byte is loaded.
- crc_cfg_en_i changing mid-burst has no effect; the change applies from the next burst.
- The engine is only advanced by this block. The engine count is 0 in IDLE and equals the number of beats fed so far in FEED.

## Timing
- Reset values: state = IDLE, beat_cnt = 0, cfg_q = 0, in_ready_o = 1, out_valid_o = 0, out_data_o = 0x00, out_crc_o = 0, crc_en_o = 0, crc_data_o = 0x00, busy_o = 0.
- Data latency: a beat accepted at edge N is presented on out_* from edge N until it is consumed.
- CRC latency: with out_ready_i held high, the 8th beat is accepted at edge N, the CRC is loaded at edge N+1, and out_crc_o is high for one cycle.
- Throughput:
  - CRC enabled: 9 output cycles per burst; input stalls 1 cycle per burst.
  - CRC disabled: 8 output cycles per burst; zero stall.
- Back-to-back bursts: the first beat of the next burst can be accepted at edge N+2, and also at edge N+1 when CRC is disabled.
- Backpressure: out_ready_i low holds out_* stable and keeps in_ready_o low. It may also stall CAPTURE indefinitely; crc_code_i stays stable meanwhile because the engine is not enabled.
- Reset mid-burst: the controller and engine both return to reset values. No partial CRC beat is emitted.

## Structure
- The shared package asu_ddr5_pkg holds:
  - the state enum crc_ctrl_state_e {IDLE, FEED, CAPTURE};
  - constants CRC_BEATS = 8 and CRC_W = 8.
- No sub-module in this block. The engine is instantiated beside the controller in the lane wrapper asu_ddr5_crc_lane, which connects crc_en_o, crc_data_o and crc_code_i.

## Test plan
- Reset then idle → all outputs at reset values, crc_en_o never asserts.
- CRC enabled, beats 0x01,0x00×7, out_ready_i = 1 → 8 data beats then CRC beat 0x07 with out_crc_o = 1; exactly 9 crc_en_o pulses.
- CRC enabled, 8 beats of 0x00 → CRC beat 0x00; engine count back to 0, so a second burst 0x01,0x00×7 yields 0x07 again.
- CRC disabled → 8 beats pass unchanged, no CRC beat, crc_en_o stays 0; toggling crc_cfg_en_i at beat 4 has no effect.
- out_ready_i low for 5 cycles during beat 8 and during CAPTURE → no beat lost or duplicated, CRC byte 0x07 is held stable until accepted.
- rst_i low after beat 3 → outputs reset; the following full burst 0x01,0x00×7 produces CRC 0x07.
